// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer.
// Holds the fetch FSM state encoding, the queue entry layout, the default
// depth / reset fetch address, the data and address widths, and small
// address helpers used by the top block.
package instruction_prefetch_buffer_pkg;

    localparam int unsigned IPB_XLEN  = 32;
    localparam int unsigned IPB_AW    = 32;
    localparam int unsigned IPB_DEPTH = 4;
    localparam logic [IPB_AW-1:0] IPB_RESET_PC = 32'h0000_0000;

    // IDLE: no request; REQUEST: response will be queued; DISCARD: response dropped
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQUEST = 2'b01,
        ST_DISCARD = 2'b10
    } ipb_state_e;

    typedef struct packed {
        logic [IPB_AW-1:0]   pc;
        logic [IPB_XLEN-1:0] instr;
    } ipb_entry_t;

    // Force an address onto a word boundary (low two bits cleared)
    function automatic logic [IPB_AW-1:0] ipb_word_align(input logic [IPB_AW-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential next word address, wrapping modulo 2^32
    function automatic logic [IPB_AW-1:0] ipb_next_pc(input logic [IPB_AW-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_prefetch_buffer_if.sv
// Bus bundle between the decode/memory side and the prefetch buffer.
//   Redirect/RedirectPC : flush and refetch from a new target
//   Stall               : hold the head entry (no consume)
//   MemRequest/MemAddress, MemReady/MemData : instruction memory handshake
//   Instruction/InstructionPC/PC4/InstructionValid : head of queue
// master = core/memory side, slave = prefetch buffer.
interface instruction_prefetch_buffer_if;
    import instruction_prefetch_buffer_pkg::*;

    logic                Redirect;
    logic [IPB_AW-1:0]   RedirectPC;
    logic                Stall;
    logic                MemRequest;
    logic [IPB_AW-1:0]   MemAddress;
    logic                MemReady;
    logic [IPB_XLEN-1:0] MemData;
    logic [IPB_XLEN-1:0] Instruction;
    logic [IPB_AW-1:0]   InstructionPC;
    logic [IPB_AW-1:0]   PC4;
    logic                InstructionValid;

    modport master (
        output Redirect, RedirectPC, Stall, MemReady, MemData,
        input  MemRequest, MemAddress, Instruction, InstructionPC, PC4, InstructionValid
    );

    modport slave (
        input  Redirect, RedirectPC, Stall, MemReady, MemData,
        output MemRequest, MemAddress, Instruction, InstructionPC, PC4, InstructionValid
    );
endinterface

// File: rtl/instruction_prefetch_buffer_prefetch_fifo.sv
// prefetch_fifo: circular queue of {pc, instruction} entries.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : empty the queue; wins over push/pop in the same cycle
//   i_push, i_push_entry : append an entry (caller guarantees a free slot)
//   i_pop          : drop the head (caller guarantees non-empty)
//   o_head, o_valid, o_count : head entry (zero when empty), non-empty, fill level
module prefetch_fifo
    import instruction_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IPB_DEPTH
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  ipb_entry_t             i_push_entry,
    input  logic                   i_pop,
    output ipb_entry_t             o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ipb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Entry storage; a flushed push is never written
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Head view is forced to zero when empty so downstream sees a clean value
    always_comb begin
        o_head = '0;
        if (o_valid) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '0;
        end
    end

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// instruction_prefetch_buffer: fetches sequential instruction words into a
// small queue ahead of decode, with redirect (flush + refetch) support.
//   CLK   : single clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : slave side of instruction_prefetch_buffer_if (redirect, stall,
//           memory handshake, head-of-queue instruction)
// The fetch FSM and fetch PC live here; storage lives in prefetch_fifo.
module instruction_prefetch_buffer
    import instruction_prefetch_buffer_pkg::*;
#(
    parameter int unsigned       DEPTH    = IPB_DEPTH,
    parameter logic [IPB_AW-1:0] RESET_PC = IPB_RESET_PC
)(
    input logic                          CLK,
    input logic                          Reset,
    instruction_prefetch_buffer_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ipb_state_e        r_state;
    logic              r_mem_req;
    logic [IPB_AW-1:0] r_fetch_pc;
    logic [IPB_AW-1:0] r_mem_addr;

    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_has_slot;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [IPB_AW-1:0] w_redirect_pc;
    logic [IPB_AW-1:0] w_fetch_pc_inc;
    ipb_entry_t        w_head;
    ipb_entry_t        w_push_entry;

    assign w_redirect_pc  = ipb_word_align(bus.RedirectPC);
    assign w_fetch_pc_inc = ipb_next_pc(r_mem_addr);
    assign w_pop          = w_valid && !bus.Stall && !bus.Redirect;
    assign w_push         = (r_state == ST_REQUEST) && bus.MemReady && !bus.Redirect;
    assign w_push_entry   = '{pc: r_mem_addr, instr: bus.MemData};

    // Fill level after this cycle's push/pop; serves both the IDLE request
    // decision and the "slot left after push" decision in REQUEST.
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_has_slot   = (w_count_next < DEPTH_C);

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (CLK),
        .i_rst_n      (Reset),
        .i_flush      (bus.Redirect),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_valid      (w_valid),
        .o_count      (w_count)
    );

    // Fetch FSM: request/address registers only change when a transfer completes,
    // so MemRequest/MemAddress stay stable while MemReady is low.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Redirect) begin
                        r_state    <= ST_REQUEST;
                        r_mem_req  <= 1'b1;
                        r_fetch_pc <= w_redirect_pc;
                        r_mem_addr <= w_redirect_pc;
                    end else if (w_has_slot) begin
                        r_state    <= ST_REQUEST;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                    end
                end
                ST_REQUEST: begin
                    if (bus.Redirect && bus.MemReady) begin
                        // Transfer finishes now; drop it and go straight to the target
                        r_state    <= ST_REQUEST;
                        r_fetch_pc <= w_redirect_pc;
                        r_mem_addr <= w_redirect_pc;
                    end else if (bus.Redirect) begin
                        // Bus must stay stable: keep the old address, remember the target
                        r_state    <= ST_DISCARD;
                        r_fetch_pc <= w_redirect_pc;
                    end else if (bus.MemReady) begin
                        r_fetch_pc <= w_fetch_pc_inc;
                        r_mem_addr <= w_fetch_pc_inc;
                        if (w_has_slot) begin
                            r_state   <= ST_REQUEST;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_REQUEST;
                    end
                end
                ST_DISCARD: begin
                    if (bus.MemReady) begin
                        // Stale transfer ends; a same-cycle redirect supplies the newest target
                        r_state    <= ST_REQUEST;
                        r_fetch_pc <= bus.Redirect ? w_redirect_pc : r_fetch_pc;
                        r_mem_addr <= bus.Redirect ? w_redirect_pc : r_fetch_pc;
                    end else if (bus.Redirect) begin
                        r_state    <= ST_DISCARD;
                        r_fetch_pc <= w_redirect_pc;
                    end else begin
                        r_state <= ST_DISCARD;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MemRequest       = r_mem_req;
    assign bus.MemAddress       = r_mem_addr;
    assign bus.InstructionValid = w_valid;
    assign bus.Instruction      = w_head.instr;
    assign bus.InstructionPC    = w_head.pc;
    assign bus.PC4              = ipb_next_pc(w_head.pc);

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Self-checking bench for instruction_prefetch_buffer (DEPTH=4, RESET_PC=0).
// Table-driven vectors, hand-written corner sequences, then randomized
// traffic checked against a queue-level reference model.
module tb_instruction_prefetch_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;

    instruction_prefetch_buffer_if bus ();

    instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.MemData = mem_word(bus.MemAddress);

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [17];
    logic        found;
    int          pushes;
    logic [31:0] wrap_pc   [5];
    logic [31:0] wrap_addr [5];
    logic        wrap_req  [5];

    // reference model state
    logic [31:0] mq [$];
    logic        m_req;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_fetch;
    logic        r_redirect, r_stall, r_ready;
    logic [31:0] r_rpc;
    logic [31:0] tgt;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [129:0] snap(input logic want_addr);
        return {bus.MemRequest, want_addr ? bus.MemAddress : 32'h0, bus.InstructionValid,
                bus.Instruction, bus.InstructionPC, bus.PC4};
    endfunction

    function automatic logic [129:0] expect_v(input logic req, input logic [31:0] addr,
                                              input logic valid, input logic [31:0] pc);
        return {req, req ? addr : 32'h0, valid, valid ? mem_word(pc) : 32'h0,
                valid ? pc : 32'h0, valid ? pc + 32'd4 : 32'd4};
    endfunction

    task automatic check_out(input string name, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc);
        check(name, snap(req), expect_v(req, addr, valid, pc));
    endtask

    task automatic drive(input logic redirect, input logic [31:0] rpc,
                         input logic stall, input logic ready);
        bus.Redirect   = redirect;
        bus.RedirectPC = rpc;
        bus.Stall      = stall;
        bus.MemReady   = ready;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold reset over two edges, check reset values, release just after an edge
    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        Reset = 1'b0;
        tick();
        tick();
        check("reset_outputs", snap(1'b1), {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 32'd4});
        Reset = 1'b1;
    endtask

    // Reference: one cycle of the prefetcher described as a queue plus one
    // outstanding-request slot
    task automatic model_step(input logic redirect, input logic [31:0] rpc,
                              input logic stall, input logic ready);
        logic pop;
        pop = (mq.size() != 0) && !stall && !redirect;
        if (redirect) begin
            tgt = rpc & 32'hFFFF_FFFC;
            mq.delete();
            m_fetch = tgt;
            if (m_req && !ready) begin
                m_drop = 1'b1;
            end else begin
                m_req  = 1'b1;
                m_drop = 1'b0;
                m_addr = tgt;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_req && ready) begin
                if (!m_drop) begin
                    mq.push_back(m_addr);
                    m_fetch = m_addr + 32'd4;
                end
                m_req  = 1'b0;
                m_drop = 1'b0;
            end
            if (!m_req && (mq.size() < int'(DEPTH))) begin
                m_req  = 1'b1;
                m_addr = m_fetch;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // stall, ready | req, addr, valid, head pc
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h1C};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h20};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h24};

        wrap_pc   = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        wrap_addr = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        wrap_req  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Streaming, fill-to-full under stall, drain, empty and refill latency
        do_reset();
        for (int i = 0; i < 17; i++) begin
            check_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                      vecs[i].exp_valid, vecs[i].exp_pc);
            drive(1'b0, 32'h0, vecs[i].stall, vecs[i].ready);
            tick();
        end

        // Stall for 10 cycles with memory always ready: exactly DEPTH pushes
        do_reset();
        pushes = 0;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (bus.MemRequest && bus.MemReady) pushes++;
            tick();
        end
        check("stall_push_count", 130'(pushes), 130'(DEPTH));
        check_out("stall_full_hold", 1'b0, 32'h0, 1'b1, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("stall_release_order", {97'h0, bus.InstructionValid, bus.InstructionPC},
                  {97'h0, 1'b1, 32'(4 * k)});
            tick();
        end

        // Redirect during a slow transfer at 0x10
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!found) begin
                if (bus.MemRequest && (bus.MemAddress == 32'h10)) found = 1'b1;
                else tick();
            end
        end
        check("reach_addr_0x10", 130'(found), 130'(1));
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            check_out("discard_hold", 1'b1, 32'h10, 1'b0, 32'h0);
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        check_out("discard_hold_ready", 1'b1, 32'h10, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("discard_dropped", 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        check_out("redirect_first_valid", 1'b1, 32'h204, 1'b1, 32'h200);

        // Redirect to unaligned 0x43 with 3 queued entries and a same-cycle pop
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        check_out("three_queued", 1'b1, 32'hC, 1'b1, 32'h0);
        drive(1'b1, 32'h43, 1'b0, 1'b1);
        tick();
        check_out("redirect_flush", 1'b1, 32'h40, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("redirect_aligned", 1'b1, 32'h44, 1'b1, 32'h40);

        // Fill near the top of the address space, then pop with memory ready
        do_reset();
        drive(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("wrap%0d", k), wrap_req[k], wrap_addr[k], 1'b1, wrap_pc[k]);
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            tick();
        end

        // Reset asserted while a request waits; late MemReady must be ignored
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_out("pending_before_reset", 1'b1, 32'h0, 1'b0, 32'h0);
        #2 Reset = 1'b0;
        #1;
        check("async_reset", snap(1'b1), {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 32'd4});
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        Reset = 1'b1;
        check_out("late_ready_idle", 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_out("rerequest", 1'b1, RESET_PC, 1'b0, 32'h0);
        tick();
        check_out("rerequest_data", 1'b1, RESET_PC + 32'd4, 1'b1, RESET_PC);

        // Randomized traffic against the reference model
        do_reset();
        mq.delete();
        m_req   = 1'b0;
        m_drop  = 1'b0;
        m_addr  = RESET_PC;
        m_fetch = RESET_PC;
        for (int c = 0; c < 3000; c++) begin
            check_out($sformatf("rand%0d", c), m_req, m_addr, mq.size() != 0,
                      (mq.size() != 0) ? mq[0] : 32'h0);
            r_redirect = ($urandom_range(0, 15) == 0);
            r_rpc      = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom();
            r_stall    = ($urandom_range(0, 3) == 0);
            r_ready    = ($urandom_range(0, 2) != 0);
            drive(r_redirect, r_rpc, r_stall, r_ready);
            model_step(r_redirect, r_rpc, r_stall, r_ready);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_buffer.md
INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Redirect  input  1  branch/jump/jr taken; flush queue, refetch from RedirectPC.
REQ-006 RedirectPC  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-007 Stall  input  1  decode hold (PC/IFID write disabled); head not consumed.
REQ-008 MemRequest  output  1  instruction-memory read request.
REQ-009 MemAddress  output  32  word-aligned read address; valid while MemRequest=1.
REQ-010 MemReady  input  1  memory response; MemData valid in the same cycle.
REQ-011 MemData  input  32  instruction word returned.
REQ-012 Instruction  output  32  head-of-queue instruction; 0 when queue empty.
REQ-013 InstructionPC  output  32  address of head instruction.
REQ-014 PC4  output  32  InstructionPC + 4, mod 2^32.
REQ-015 InstructionValid  output  1  queue non-empty.

Function
REQ-016 FSM states: IDLE (no request), REQUEST (MemRequest=1, usable response), DISCARD (MemRequest=1, response dropped).
REQ-017 Handshake: once MemRequest rises, MemRequest and MemAddress stay stable until the cycle MemReady=1; transfer completes in that cycle; one outstanding request max.
REQ-018 IDLE -> REQUEST when queue has a free slot, counting an entry popped this cycle; otherwise stay IDLE.
REQ-019 REQUEST with MemReady=1 and no Redirect: push {FetchPC, MemData}, FetchPC += 4; stay in REQUEST if a slot remains after the push, else go to IDLE.
REQ-020 Redirect in REQUEST with MemReady=0 -> DISCARD; MemAddress holds the old FetchPC; RedirectPC is latched as the next FetchPC.
REQ-021 Redirect in REQUEST with MemReady=1 -> response dropped, next state REQUEST at RedirectPC.
REQ-022 DISCARD with MemReady=1 -> REQUEST at the latched redirect address; data is never pushed.
REQ-023 Redirect in DISCARD: relatch the target, stay DISCARD; the newest Redirect wins.
REQ-024 Redirect in IDLE -> REQUEST at RedirectPC next cycle.
REQ-025 Redirect empties the queue at the clock edge; it overrides any same-cycle pop or push.
REQ-026 Pop occurs when InstructionValid=1 and Stall=0 and Redirect=0; pop advances the head next cycle.
REQ-027 Simultaneous push and pop: count unchanged, both take effect.
REQ-028 Full: no request issued; Stall with a full queue keeps all state frozen except the FSM in DISCARD.
REQ-029 Empty: InstructionValid=0; Instruction, InstructionPC, PC4 are don't-care but driven 0 / 0 / 4.
REQ-030 Latency: response accepted in cycle N -> InstructionValid=1 in cycle N+1 if the queue was empty; no combinational MemData-to-Instruction path.
REQ-031 Read/write pointers wrap modulo DEPTH; FetchPC wraps modulo 2^32 with no fault.

Reset
REQ-032 While Reset=0: FSM=IDLE, FetchPC=RESET_PC, queue empty, MemRequest=0, InstructionValid=0, MemAddress=RESET_PC.
REQ-033 First rising edge after Reset releases -> REQUEST; MemRequest=1 with MemAddress=RESET_PC.
REQ-034 Reset asserted mid-transfer abandons the transfer immediately; no response is consumed after release unless it is re-requested.

Structure
REQ-035 Shared constants file holds the FSM state encodings (2-bit), the DEPTH default, the RESET_PC default, and the instruction/address widths (32).
REQ-036 Sub-module prefetch_fifo: storage, pointers, count, push/pop/flush; the FSM and FetchPC stay in the top block.

Verification
REQ-037 Reset release, MemReady tied high, Stall=0: addresses 0,4,8,... issued every cycle; Instruction stream matches memory with InstructionPC 0,4,8.
REQ-038 Stall=1 for 10 cycles, MemReady high, DEPTH=4: exactly 4 pushes, then MemRequest=0; head stays at PC 0; on release, pops resume in order.
REQ-039 MemReady delayed 3 cycles at address 0x10, Redirect to 0x200 in the 1st wait cycle: MemAddress holds 0x10 until ready; that data is discarded; next request is 0x200; first valid InstructionPC=0x200.
REQ-040 Redirect to 0x43 with 3 queued entries and a same-cycle pop: next cycle InstructionValid=0; next MemAddress=0x40.
REQ-041 Full queue, same-cycle pop and MemReady: count stays 4, order preserved; FetchPC 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-042 Reset=0 asserted mid-wait: outputs immediately take reset values; the late MemReady is ignored.
